bridge_ahb_slave_if: RTL and testbench
======================================

BRIDGE_AHB_SLAVE_IF -- requirements
Module: bridge_ahb_slave_if

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter SLAVES, default 4, giving the number of APB slave select flags.
REQ-003 HCLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous and active-low.
REQ-005 Inputs SHALL be:
- HSELAPB  in  1  bridge select from the AHB decoder.
- HREADY_IN  in  1  bus-wide HREADY.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  write/read control.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type.
- HADDR  in  WIDTH  address.
- HWDATA  in  WIDTH  write data.
REQ-006 Outputs SHALL be:
- valid  out  1  accepted transfer to the APB controller.
- HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3  out  WIDTH  address delayed by 1, 2 and 3 cycles.
- INC_ADDR  out  WIDTH  next expected burst address.
- HWDATA_REG  out  WIDTH  HWDATA delayed by 1 cycle.
- flag_timer, flag_interruptc, flag_remap_pause_controller, flag_slave4  out  1 each  slave decode.
- HRESP  out  2  OKAY=00, ERROR=01.
- HREADY_RESP  out  1  bridge-side HREADYOUT contribution.

Function
REQ-007 An access SHALL be "active" when HSELAPB=1, HREADY_IN=1 and HTRANS is NONSEQ or SEQ.
REQ-008 valid SHALL be combinational: 1 when an access is active, the address is mapped, the access is aligned, there is no SEQ mismatch, and the error FSM is in OK; otherwise 0.
REQ-009 The address map SHALL be:
- timer 0x8000_0000-0x80FF_FFFF
- interruptc 0x8100_0000-0x81FF_FFFF
- remap_pause_controller 0x8200_0000-0x82FF_FFFF
- slave4 0x8300_0000-0x83FF_FFFF
- anything else is unmapped.
REQ-010 The flags SHALL be decoded combinationally from HADDR_REG_D1, at most one flag high at a time, and all flags low when HADDR_REG_D1 is unmapped.
REQ-011 Misalignment SHALL be defined as any of:
- HSIZE=001 with HADDR[0]=1
- HSIZE=010 with HADDR[1:0]!=00
- HSIZE>010
REQ-012 HADDR_REG_D1 SHALL load HADDR on clocks where HREADY_IN=1 and hold otherwise; HADDR_REG_D2 and HADDR_REG_D3 SHALL shift from D1 and D2 every clock.
REQ-013 HWDATA_REG SHALL load HWDATA every clock.
REQ-014 The burst counter SHALL behave as follows:
- On an accepted NONSEQ it loads beats-1, where beats is 1 for SINGLE/INCR, 4 for WRAP4/INCR4, 8 for *8, and 16 for *16.
- On an accepted SEQ it decrements, saturating at 0.
- BUSY and IDLE hold it.
REQ-015 INC_ADDR SHALL be HADDR_REG_D1 + (1<<HSIZE_REG) for INCR types. For WRAPn, bits below log2(n*(1<<HSIZE_REG)) SHALL wrap within that boundary and the upper bits SHALL be kept. The result is truncated to WIDTH.
REQ-016 A SEQ access whose HADDR differs from INC_ADDR SHALL count as a SEQ mismatch.
REQ-017 The error FSM SHALL have states OK, ERR1 and ERR2.
- OK -> ERR1 on an active access that is unmapped, misaligned or a SEQ mismatch.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> OK unconditionally.
REQ-018 The FSM outputs SHALL be: OK drives HRESP=00, HREADY_RESP=1; ERR1 drives HRESP=01, HREADY_RESP=0; ERR2 drives HRESP=01, HREADY_RESP=1.
REQ-019 valid SHALL be 0 in ERR1 and ERR2 regardless of inputs, and HTRANS=IDLE during ERR1 SHALL NOT shorten the error response.
REQ-020 BUSY or IDLE while selected SHALL give an OKAY response with valid=0.
REQ-021 Simultaneous error and SEQ on the same cycle SHALL take the error path without decrementing the burst counter.

Reset
REQ-022 While HRESETn=0:
- all registers, address pipeline, HWDATA_REG and burst counter SHALL be 0
- the FSM SHALL be OK
- HRESP SHALL be 00 and HREADY_RESP SHALL be 1
- valid and the flags SHALL be 0
REQ-023 Reset asserted in ERR1 or ERR2 SHALL abort the error response immediately, and the first post-reset cycle SHALL be OK.

Verification
REQ-024 NONSEQ write, HADDR=0x8000_0004, HSIZE=010, HSELAPB=1 -> valid=1 that cycle; next cycle HADDR_REG_D1=0x8000_0004, flag_timer=1, INC_ADDR=0x8000_0008.
REQ-025 WRAP4 word burst starting at 0x8100_0008 -> INC_ADDR sequence 0x8100_000C, 0x8100_0000, 0x8100_0004, and valid=1 on all 4 beats.
REQ-026 NONSEQ to 0x9000_0000 -> valid=0, then HRESP=01/HREADY_RESP=0 for one cycle, then HRESP=01/HREADY_RESP=1, then OKAY.
REQ-027 HSIZE=010 with HADDR=0x8200_0002 -> two-cycle ERROR; SEQ with HADDR not equal to INC_ADDR -> two-cycle ERROR.
REQ-028 HRESETn pulsed low during ERR1 -> HRESP=00, HREADY_RESP=1 and all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/bridge_ahb_slave_if.sv
// AHB slave side of the AHB-to-APB bridge: qualifies transfers, decodes the APB
// slave, tracks the expected burst address and generates the two-cycle ERROR.
module bridge_ahb_slave_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSELAPB,
  input  logic             HREADY_IN,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [WIDTH-1:0] HADDR,
  input  logic [WIDTH-1:0] HWDATA,
  output logic             valid,
  output logic [WIDTH-1:0] HADDR_REG_D1,
  output logic [WIDTH-1:0] HADDR_REG_D2,
  output logic [WIDTH-1:0] HADDR_REG_D3,
  output logic [WIDTH-1:0] INC_ADDR,
  output logic [WIDTH-1:0] HWDATA_REG,
  output logic             flag_timer,
  output logic             flag_interruptc,
  output logic             flag_remap_pause_controller,
  output logic             flag_slave4,
  output logic [1:0]       HRESP,
  output logic             HREADY_RESP
);

  localparam logic [1:0] TRANS_SEQ = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAP_BASE = WIDTH'(32'h8000_0000);
  localparam logic [WIDTH-1:0] MAP_LAST = WIDTH'(32'h83FF_FFFF);
  localparam logic [2:0] NUM_REGIONS    = (SLAVES >= 4) ? 3'd4 : 3'(SLAVES);

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} err_state_e;

  // Each slave owns one 16 MB window; bits [25:24] pick the slave.
  function automatic logic addr_mapped(input logic [WIDTH-1:0] addr);
    return (addr >= MAP_BASE) && (addr <= MAP_LAST) &&
           ({1'b0, addr[25:24]} < NUM_REGIONS);
  endfunction

  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] addr,
                                                 input logic [2:0]       size,
                                                 input logic [2:0]       burst);
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] incr;
    logic [WIDTH-1:0] mask;
    step = ONE << size;
    incr = addr + step;
    case (burst)
      BURST_WRAP4:  span = step << 2;
      BURST_WRAP8:  span = step << 3;
      BURST_WRAP16: span = step << 4;
      default:      span = '0;
    endcase
    if (span == '0) begin
      return incr;
    end
    mask = span - ONE;
    return (addr & ~mask) | (incr & mask);
  endfunction

  function automatic logic [3:0] beats_minus1(input logic [2:0] burst);
    case (burst)
      BURST_SINGLE, BURST_INCR:  return 4'd0;
      BURST_WRAP4, BURST_INCR4:  return 4'd3;
      BURST_WRAP8, BURST_INCR8:  return 4'd7;
      default:                   return 4'd15;
    endcase
  endfunction

  err_state_e       state_q;
  logic [1:0]       hresp_q;
  logic             hready_resp_q;

  logic [WIDTH-1:0] haddr_d1_q, haddr_d1_d;
  logic [WIDTH-1:0] haddr_d2_q, haddr_d2_d;
  logic [WIDTH-1:0] haddr_d3_q, haddr_d3_d;
  logic [WIDTH-1:0] inc_addr_q, inc_addr_d;
  logic [WIDTH-1:0] hwdata_q, hwdata_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;

  logic             active;
  logic             is_seq;
  logic             mapped;
  logic             misaligned;
  logic             seq_mismatch;
  logic             err_event;
  logic             d1_mapped;
  logic [1:0]       d1_idx;
  logic [3:0]       flag_vec;
  logic             unused_inputs;

  assign active       = HSELAPB && HREADY_IN && HTRANS[1];
  assign is_seq       = (HTRANS == TRANS_SEQ);
  assign mapped       = addr_mapped(HADDR);
  assign seq_mismatch = active && is_seq && (HADDR != inc_addr_q);
  assign err_event    = active && (!mapped || misaligned || seq_mismatch);
  assign valid        = HRESETn && (state_q == ST_OK) && active && mapped &&
                        !misaligned && !seq_mismatch;

  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = HADDR[0];
      3'b010:  misaligned = |HADDR[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // INC_ADDR is computed ahead and loaded with the same enable as D1, so it is
  // always next_addr(HADDR_REG_D1, registered HSIZE, registered HBURST).
  always_comb begin
    haddr_d1_d  = HREADY_IN ? HADDR : haddr_d1_q;
    inc_addr_d  = HREADY_IN ? next_addr(HADDR, HSIZE, HBURST) : inc_addr_q;
    haddr_d2_d  = haddr_d1_q;
    haddr_d3_d  = haddr_d2_q;
    hwdata_d    = HWDATA;
    burst_cnt_d = burst_cnt_q;
    if (valid && !is_seq) begin
      burst_cnt_d = beats_minus1(HBURST);
    end else if (valid && is_seq && (burst_cnt_q != 4'd0)) begin
      burst_cnt_d = burst_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_d1_q  <= '0;
      haddr_d2_q  <= '0;
      haddr_d3_q  <= '0;
      inc_addr_q  <= '0;
      hwdata_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      haddr_d1_q  <= haddr_d1_d;
      haddr_d2_q  <= haddr_d2_d;
      haddr_d3_q  <= haddr_d3_d;
      inc_addr_q  <= inc_addr_d;
      hwdata_q    <= hwdata_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Once in ERR1 the response runs to completion whatever the bus does.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_OK;
      hresp_q       <= RESP_OKAY;
      hready_resp_q <= 1'b1;
    end else begin
      case (state_q)
        ST_OK: begin
          if (err_event) begin
            state_q       <= ST_ERR1;
            hresp_q       <= RESP_ERROR;
            hready_resp_q <= 1'b0;
          end
        end
        ST_ERR1: begin
          state_q       <= ST_ERR2;
          hresp_q       <= RESP_ERROR;
          hready_resp_q <= 1'b1;
        end
        ST_ERR2: begin
          state_q       <= ST_OK;
          hresp_q       <= RESP_OKAY;
          hready_resp_q <= 1'b1;
        end
        default: begin
          state_q       <= ST_OK;
          hresp_q       <= RESP_OKAY;
          hready_resp_q <= 1'b1;
        end
      endcase
    end
  end

  assign d1_mapped = addr_mapped(haddr_d1_q);
  assign d1_idx    = haddr_d1_q[25:24];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_flag
      if (gi < SLAVES) begin : g_on
        assign flag_vec[gi] = d1_mapped && (d1_idx == 2'(gi));
      end else begin : g_off
        assign flag_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign flag_timer                  = flag_vec[0];
  assign flag_interruptc             = flag_vec[1];
  assign flag_remap_pause_controller = flag_vec[2];
  assign flag_slave4                 = flag_vec[3];

  assign HADDR_REG_D1 = haddr_d1_q;
  assign HADDR_REG_D2 = haddr_d2_q;
  assign HADDR_REG_D3 = haddr_d3_q;
  assign INC_ADDR     = inc_addr_q;
  assign HWDATA_REG   = hwdata_q;
  assign HRESP        = hresp_q;
  assign HREADY_RESP  = hready_resp_q;

  // HWRITE is forwarded to the APB side elsewhere; nothing here depends on it.
  assign unused_inputs = ^{HWRITE, burst_cnt_q};

endmodule

// File: tb/tb_bridge_ahb_slave_if.sv
// Directed bench for bridge_ahb_slave_if: decode, pipeline, bursts, ERROR response, reset.
module tb_bridge_ahb_slave_if;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, WRAP4 = 3'b010, INCR4 = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSELAPB = 1'b0;
  logic        HREADY_IN = 1'b1;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = 3'b000;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        valid;
  logic [31:0] HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3, INC_ADDR, HWDATA_REG;
  logic        flag_timer, flag_interruptc, flag_remap_pause_controller, flag_slave4;
  logic [1:0]  HRESP;
  logic        HREADY_RESP;

  int checks = 0;
  int failures = 0;

  logic [3:0] flags;
  logic [2:0] resp;
  assign flags = {flag_slave4, flag_remap_pause_controller, flag_interruptc, flag_timer};
  assign resp  = {HRESP, HREADY_RESP};

  bridge_ahb_slave_if #(.WIDTH(32), .SLAVES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELAPB(HSELAPB), .HREADY_IN(HREADY_IN),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HADDR(HADDR), .HWDATA(HWDATA), .valid(valid),
    .HADDR_REG_D1(HADDR_REG_D1), .HADDR_REG_D2(HADDR_REG_D2), .HADDR_REG_D3(HADDR_REG_D3),
    .INC_ADDR(INC_ADDR), .HWDATA_REG(HWDATA_REG),
    .flag_timer(flag_timer), .flag_interruptc(flag_interruptc),
    .flag_remap_pause_controller(flag_remap_pause_controller), .flag_slave4(flag_slave4),
    .HRESP(HRESP), .HREADY_RESP(HREADY_RESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic drive(input logic sel, input logic rdy, input logic [1:0] trans,
                       input logic [2:0] size, input logic [2:0] burst,
                       input logic [31:0] addr, input logic [31:0] wdata);
    HSELAPB = sel; HREADY_IN = rdy; HTRANS = trans; HSIZE = size;
    HBURST = burst; HADDR = addr; HWDATA = wdata; HWRITE = 1'b1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, IDLE, 3'b010, SINGLE, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8000_0004, 32'hDEAD_BEEF);
    repeat (2) step();
    mid();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL reset_resp got=%03b exp=001", resp); end
    checks++; if ({HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3} !== 96'h0) begin failures++;
      $display("FAIL reset_addr_pipe got=%h/%h/%h exp=0", HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3); end
    checks++; if (INC_ADDR !== 32'h0) begin failures++; $display("FAIL reset_inc_addr got=%h exp=0", INC_ADDR); end
    checks++; if (HWDATA_REG !== 32'h0) begin failures++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA_REG); end
    checks++; if (flags !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    step();
    HRESETn = 1'b1;
    idle();
    mid();
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL post_reset_resp got=%03b exp=001", resp); end
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8000_0004, 32'h1234_5678);
    mid();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", valid); end
    step();
    idle();
    mid();
    checks++; if (HADDR_REG_D1 !== 32'h8000_0004) begin failures++; $display("FAIL single_d1 got=%h exp=80000004", HADDR_REG_D1); end
    checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL single_flags got=%b exp=0001", flags); end
    checks++; if (INC_ADDR !== 32'h8000_0008) begin failures++; $display("FAIL single_inc got=%h exp=80000008", INC_ADDR); end
    checks++; if (HWDATA_REG !== 32'h1234_5678) begin failures++; $display("FAIL single_hwdata got=%h exp=12345678", HWDATA_REG); end
    checks++; if ({valid, resp} !== 4'b0001) begin failures++; $display("FAIL idle_okay got=%b exp=0001", {valid, resp}); end
    step();
    mid();
    checks++; if ({HADDR_REG_D1, HADDR_REG_D2} !== {32'h0, 32'h8000_0004}) begin failures++;
      $display("FAIL pipe_d2 got=%h/%h exp=00000000/80000004", HADDR_REG_D1, HADDR_REG_D2); end
    step();
    mid();
    checks++; if (HADDR_REG_D3 !== 32'h8000_0004) begin failures++; $display("FAIL pipe_d3 got=%h exp=80000004", HADDR_REG_D3); end
    step();
  endtask

  task automatic test_flags();
    logic [31:0] addr;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h8000_0010 + (32'(i) << 24);
      drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, addr, 32'h0);
      mid();
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL flags_valid[%0d] got=%0b exp=1", i, valid); end
      step();
      idle();
      mid();
      checks++; if (flags !== (4'b0001 << i)) begin failures++;
        $display("FAIL flags_decode[%0d] got=%b exp=%b", i, flags, 4'b0001 << i); end
      step();
    end
    drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8200_0040, 32'h0);
    step();
    drive(1'b1, 1'b0, NSEQ, 3'b010, SINGLE, 32'h9000_0000, 32'h0);
    mid();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL hold_valid got=%0b exp=0", valid); end
    step();
    idle();
    mid();
    checks++; if ({HADDR_REG_D1, INC_ADDR} !== {32'h8200_0040, 32'h8200_0044}) begin failures++;
      $display("FAIL hold_d1 got=%h/%h exp=82000040/82000044", HADDR_REG_D1, INC_ADDR); end
    checks++; if ({flags, resp} !== 7'b0100_001) begin failures++; $display("FAIL hold_flags_resp got=%b exp=0100001", {flags, resp}); end
    step();
  endtask

  task automatic test_not_active();
    logic       sel [3];
    logic [1:0] trans [3];
    sel   = '{1'b0, 1'b1, 1'b1};
    trans = '{NSEQ, BUSY, IDLE};
    for (int i = 0; i < 3; i++) begin
      drive(sel[i], 1'b1, trans[i], 3'b010, SINGLE, 32'h9000_0000, 32'h0);
      mid();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL inactive_valid[%0d] got=%0b exp=0", i, valid); end
      step();
      idle();
      mid();
      checks++; if (resp !== 3'b001) begin failures++; $display("FAIL inactive_resp[%0d] got=%03b exp=001", i, resp); end
      step();
    end
  endtask

  task automatic test_wrap4();
    logic [31:0] addrs [4];
    logic [31:0] incs [4];
    addrs = '{32'h8100_0008, 32'h8100_000C, 32'h8100_0000, 32'h8100_0004};
    incs  = '{32'h8100_000C, 32'h8100_0000, 32'h8100_0004, 32'h8100_0008};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, (k == 0) ? NSEQ : SEQ, 3'b010, WRAP4, addrs[k], 32'h0);
      mid();
      if (k > 0) begin
        checks++; if (INC_ADDR !== incs[k-1]) begin failures++;
          $display("FAIL wrap4_inc[%0d] got=%h exp=%h", k, INC_ADDR, incs[k-1]); end
      end
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL wrap4_valid[%0d] got=%0b exp=1", k, valid); end
      step();
    end
    idle();
    mid();
    checks++; if (INC_ADDR !== incs[3]) begin failures++; $display("FAIL wrap4_inc_last got=%h exp=%h", INC_ADDR, incs[3]); end
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL wrap4_resp got=%03b exp=001", resp); end
    step();
  endtask

  task automatic test_incr_half();
    drive(1'b1, 1'b1, NSEQ, 3'b001, INCR, 32'h8000_0FFE, 32'h0);
    step();
    drive(1'b1, 1'b1, SEQ, 3'b001, INCR, 32'h8000_1000, 32'h0);
    mid();
    checks++; if ({valid, INC_ADDR} !== {1'b1, 32'h8000_1000}) begin failures++;
      $display("FAIL incr_half got=%0b/%h exp=1/80001000", valid, INC_ADDR); end
    step();
    idle();
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [2:0]  sizes [4];
    addrs = '{32'h9000_0000, 32'h8200_0002, 32'h8000_0001, 32'h8000_0000};
    sizes = '{3'b010, 3'b010, 3'b001, 3'b011};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, NSEQ, sizes[k], SINGLE, addrs[k], 32'h0);
      mid();
      checks++; if ({valid, resp} !== 4'b0001) begin failures++; $display("FAIL err_start[%0d] got=%b exp=0001", k, {valid, resp}); end
      step();
      if (k % 2 == 0) idle();
      else drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8000_0000, 32'h0);
      mid();
      checks++; if ({valid, resp} !== 4'b0010) begin failures++; $display("FAIL err1[%0d] got=%b exp=0010", k, {valid, resp}); end
      step();
      drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8000_0000, 32'h0);
      mid();
      checks++; if ({valid, resp} !== 4'b0011) begin failures++; $display("FAIL err2[%0d] got=%b exp=0011", k, {valid, resp}); end
      step();
      idle();
      mid();
      checks++; if (resp !== 3'b001) begin failures++; $display("FAIL err_done[%0d] got=%03b exp=001", k, resp); end
      step();
    end
  endtask

  task automatic test_seq_mismatch();
    drive(1'b1, 1'b1, NSEQ, 3'b010, INCR4, 32'h8300_0000, 32'h0);
    mid();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mismatch_first got=%0b exp=1", valid); end
    step();
    drive(1'b1, 1'b1, SEQ, 3'b010, INCR4, 32'h8300_0008, 32'h0);
    mid();
    checks++; if ({valid, INC_ADDR} !== {1'b0, 32'h8300_0004}) begin failures++;
      $display("FAIL mismatch_seq got=%0b/%h exp=0/83000004", valid, INC_ADDR); end
    step();
    idle();
    mid();
    checks++; if (resp !== 3'b010) begin failures++; $display("FAIL mismatch_err1 got=%03b exp=010", resp); end
    step();
    mid();
    checks++; if (resp !== 3'b011) begin failures++; $display("FAIL mismatch_err2 got=%03b exp=011", resp); end
    step();
    mid();
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL mismatch_done got=%03b exp=001", resp); end
    step();
  endtask

  task automatic test_reset_in_err();
    drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h9000_0000, 32'hCAFE_0001);
    step();
    drive(1'b1, 1'b1, NSEQ, 3'b010, SINGLE, 32'h8000_0000, 32'h0);
    mid();
    checks++; if ({resp, HADDR_REG_D1, HWDATA_REG} !== {3'b010, 32'h9000_0000, 32'hCAFE_0001}) begin failures++;
      $display("FAIL rst_err_pre got=%03b/%h/%h exp=010/90000000/cafe0001", resp, HADDR_REG_D1, HWDATA_REG); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if ({valid, resp} !== 4'b0001) begin failures++; $display("FAIL rst_err_resp got=%b exp=0001", {valid, resp}); end
    checks++; if ({HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3, INC_ADDR, HWDATA_REG} !== 160'h0) begin failures++;
      $display("FAIL rst_err_regs got=%h/%h/%h/%h/%h exp=0", HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3, INC_ADDR, HWDATA_REG); end
    checks++; if (flags !== 4'b0) begin failures++; $display("FAIL rst_err_flags got=%b exp=0000", flags); end
    step();
    HRESETn = 1'b1;
    idle();
    mid();
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL rst_err_post1 got=%03b exp=001", resp); end
    step();
    mid();
    checks++; if (resp !== 3'b001) begin failures++; $display("FAIL rst_err_post2 got=%03b exp=001", resp); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_not_active();
    test_wrap4();
    test_incr_half();
    test_errors();
    test_seq_mismatch();
    test_reset_in_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
